// File: rtl/ntt_engine.sv
`default_nettype none
// ============================================================================
//  Module   : ntt_engine
//  Purpose  : Parametrised Kyber-style incomplete number-theoretic transform.
//             mode=0 runs the forward NTT, mode=1 the inverse NTT including
//             the final multiply by F = (N/2)^-1 mod Q. One butterfly per
//             clock over an internal register file of canonical residues.
//  Revision : 1.0  initial release (forward + inverse in one engine)
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1      rising-edge clock
//    rst        in   1      asynchronous active-high reset
//    start_ntt  in   1      start request, sampled only in IDLE
//    mode       in   1      0 = forward, 1 = inverse, sampled with start_ntt
//    f          in   NxW    signed input coefficients, sampled in LOAD
//    busy       out  1      high from LOAD through SCALE
//    done_ntt   out  1      one-cycle pulse when f_hat is updated
//    f_hat      out  NxW    result in [0,Q-1], held until the next done_ntt
// ============================================================================
module ntt_engine #(
  parameter int N    = 256,
  parameter int Q    = 3329,
  parameter int F    = 3303,
  parameter int ZETA = 17,
  parameter int W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_ntt,
  input  logic                mode,
  input  logic signed [W-1:0] f     [N],
  output logic                busy,
  output logic                done_ntt,
  output logic signed [W-1:0] f_hat [N]
);

  localparam int LOGN = $clog2(N);
  localparam int QW   = $clog2(Q);
  localparam int PW   = 2 * QW;
  localparam int KW   = LOGN - 1;

  localparam logic [QW:0]           c_Q1 = (QW+1)'(Q);
  localparam logic [PW-1:0]         c_QP = PW'(Q);
  localparam logic signed [W-1:0]   c_QS = W'(Q);
  localparam logic [QW-1:0]         c_FR = QW'(F % Q);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_LOAD  = 3'd1;
  localparam logic [2:0] c_ST_BFLY  = 3'd2;
  localparam logic [2:0] c_ST_SCALE = 3'd3;
  localparam logic [2:0] c_ST_DONE  = 3'd4;

  if (((F * (N / 2)) % Q) != 1) begin : g_chk_f
    $error("ntt_engine: F is not the inverse of N/2 modulo Q");
  end
  if (W < 2 * QW + 1) begin : g_chk_w
    $error("ntt_engine: W too narrow for the modulus");
  end

  // ZETA^bitrev_KW(k) mod Q. Square-and-multiply walks the exponent from its
  // MSB, which is bit 0 of k after the reversal.
  function automatic longint zeta_pow(input int k);
    longint r;
    r = 1;
    for (int i = 0; i < KW; i++) begin
      r = (r * r) % longint'(Q);
      if (((k >> i) & 1) != 0) r = (r * longint'(ZETA)) % longint'(Q);
    end
    return r;
  endfunction

  function automatic logic [QW-1:0] mulmod(input logic [QW-1:0] a, input logic [QW-1:0] b);
    logic [PW-1:0] p;
    p = PW'(a) * PW'(b);
    return QW'(p % c_QP);
  endfunction

  function automatic logic [QW-1:0] addmod(input logic [QW-1:0] a, input logic [QW-1:0] b);
    logic [QW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= c_Q1) ? QW'(s - c_Q1) : QW'(s);
  endfunction

  // a - b, biased by Q so the intermediate never goes negative.
  function automatic logic [QW-1:0] submod(input logic [QW-1:0] a, input logic [QW-1:0] b);
    logic [QW:0] s;
    s = {1'b0, a} + c_Q1 - {1'b0, b};
    return (s >= c_Q1) ? QW'(s - c_Q1) : QW'(s);
  endfunction

  logic [2:0]      r_state, w_next;
  logic            r_mode;
  logic            r_done;
  logic [LOGN-1:0] r_j;
  logic [LOGN-1:0] r_len;
  logic [KW-1:0]   r_k;

  logic [QW-1:0]   w_zrom [N/2];
  logic [QW-1:0]   w_coef [N];
  logic [QW-1:0]   w_ld   [N];

  logic [LOGN-1:0] w_jl;
  logic [QW-1:0]   w_a, w_b, w_z, w_t, w_diff, w_lo, w_hi, w_scaled;
  logic            w_grp_end, w_layer_end, w_last, w_scale_last;

  for (genvar g = 0; g < N / 2; g++) begin : g_zrom
    localparam logic [QW-1:0] c_Z = QW'(zeta_pow(g));
    assign w_zrom[g] = c_Z;
  end

  // Butterfly operands and results
  assign w_jl     = r_j + r_len;
  assign w_a      = w_coef[r_j];
  assign w_b      = w_coef[w_jl];
  assign w_z      = w_zrom[r_k];
  assign w_t      = mulmod(w_z, w_b);
  assign w_diff   = submod(w_b, w_a);
  assign w_lo     = r_mode ? addmod(w_a, w_b)   : addmod(w_a, w_t);
  assign w_hi     = r_mode ? mulmod(w_z, w_diff) : submod(w_a, w_t);
  assign w_scaled = mulmod(w_a, c_FR);

  // j reaching the top of its half-group closes the group; the group whose
  // upper partner is coefficient N-1 closes the layer.
  assign w_grp_end    = ((r_j & (r_len - LOGN'(1))) == (r_len - LOGN'(1)));
  assign w_layer_end  = w_grp_end && (w_jl == LOGN'(N - 1));
  assign w_last       = w_layer_end && (r_len == (r_mode ? LOGN'(N / 2) : LOGN'(2)));
  assign w_scale_last = (r_j == LOGN'(N - 1));

  // Per-coefficient storage: input reduction, working value and result.
  for (genvar g = 0; g < N; g++) begin : g_cell
    logic signed [W-1:0] w_rem;
    logic [QW-1:0]       r_coef;
    logic [QW-1:0]       r_res;

    // Signed % keeps the dividend's sign; fold negatives back into [0,Q-1].
    assign w_rem     = f[g] % c_QS;
    assign w_ld[g]   = (w_rem < 0) ? QW'(w_rem + c_QS) : QW'(w_rem);
    assign w_coef[g] = r_coef;
    assign f_hat[g]  = {{(W-QW){1'b0}}, r_res};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_coef <= '0;
      end else if (r_state == c_ST_LOAD) begin
        r_coef <= w_ld[g];
      end else if (r_state == c_ST_BFLY && r_j == LOGN'(g)) begin
        r_coef <= w_lo;
      end else if (r_state == c_ST_BFLY && w_jl == LOGN'(g)) begin
        r_coef <= w_hi;
      end else if (r_state == c_ST_SCALE && r_j == LOGN'(g)) begin
        r_coef <= w_scaled;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_res <= '0;
      end else if (r_state == c_ST_DONE) begin
        r_res <= r_coef;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_ST_IDLE;
    else     r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE:  if (start_ntt) w_next = c_ST_LOAD;
      c_ST_LOAD:  w_next = c_ST_BFLY;
      c_ST_BFLY:  if (w_last) w_next = r_mode ? c_ST_SCALE : c_ST_DONE;
      c_ST_SCALE: if (w_scale_last) w_next = c_ST_DONE;
      c_ST_DONE:  w_next = c_ST_IDLE;
      default:    w_next = c_ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (r_state == c_ST_LOAD) || (r_state == c_ST_BFLY) || (r_state == c_ST_SCALE);
  end

  // done_ntt rises together with the f_hat update made at the DONE edge.
  assign done_ntt = r_done;

  // Sequencing counters and mode latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= 1'b0;
      r_done <= 1'b0;
      r_j    <= '0;
      r_len  <= '0;
      r_k    <= '0;
    end else begin
      r_done <= (r_state == c_ST_DONE);
      case (r_state)
        c_ST_IDLE: begin
          if (start_ntt) r_mode <= mode;
        end
        c_ST_LOAD: begin
          r_j   <= '0;
          r_len <= r_mode ? LOGN'(2) : LOGN'(N / 2);
          r_k   <= r_mode ? KW'(N / 2 - 1) : KW'(1);
        end
        c_ST_BFLY: begin
          if (w_last || w_layer_end) begin
            r_j <= '0;
          end else if (w_grp_end) begin
            r_j <= w_jl + LOGN'(1);
          end else begin
            r_j <= r_j + LOGN'(1);
          end
          if (w_layer_end && !w_last) r_len <= r_mode ? (r_len << 1) : (r_len >> 1);
          if (w_grp_end) r_k <= r_mode ? (r_k - KW'(1)) : (r_k + KW'(1));
        end
        c_ST_SCALE: begin
          r_j <= r_j + LOGN'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ntt_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ntt_engine
//  Purpose  : Self-checking bench for ntt_engine against a loop-level
//             reference NTT/INTT, with randomized coefficient vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ntt_engine;

  localparam int N       = 256;
  localparam int Q       = 3329;
  localparam int F       = 3303;
  localparam int ZETA    = 17;
  localparam int W       = 32;
  localparam int KW      = $clog2(N) - 1;
  localparam int B       = (N / 2) * KW;
  localparam int LAT_FWD = 2 + B;
  localparam int LAT_INV = 2 + B + N;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start_ntt = 1'b0;
  logic                mode = 1'b0;
  logic signed [W-1:0] f     [N];
  logic                busy;
  logic                done_ntt;
  logic signed [W-1:0] f_hat [N];

  int     n_checks = 0;
  int     n_errors = 0;
  longint zt    [N/2];
  longint vec   [N];
  longint orig  [N];
  longint ref_w [N];

  ntt_engine #(.N(N), .Q(Q), .F(F), .ZETA(ZETA), .W(W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start_ntt (start_ntt),
    .mode      (mode),
    .f         (f),
    .busy      (busy),
    .done_ntt  (done_ntt),
    .f_hat     (f_hat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic int brv(input int k);
    int r = 0;
    for (int i = 0; i < KW; i++)
      if ((k & (1 << i)) != 0) r = r | (1 << (KW - 1 - i));
    return r;
  endfunction

  task automatic build_zetas;
    for (int k = 0; k < N / 2; k++) begin
      longint z = 1;
      repeat (brv(k)) z = (z * ZETA) % Q;
      zt[k] = z;
    end
  endtask

  // Reference transform on vec -> ref_w, straight from the textbook loops.
  task automatic model(input bit m);
    int     k;
    longint t, z;
    for (int i = 0; i < N; i++) ref_w[i] = ((vec[i] % Q) + Q) % Q;
    if (!m) begin
      k = 1;
      for (int len = N / 2; len >= 2; len = len / 2)
        for (int s = 0; s < N; s += 2 * len) begin
          z = zt[k]; k++;
          for (int j = s; j < s + len; j++) begin
            t              = (z * ref_w[j + len]) % Q;
            ref_w[j + len] = (ref_w[j] - t + Q) % Q;
            ref_w[j]       = (ref_w[j] + t) % Q;
          end
        end
    end else begin
      k = N / 2 - 1;
      for (int len = 2; len <= N / 2; len = len * 2)
        for (int s = 0; s < N; s += 2 * len) begin
          z = zt[k]; k--;
          for (int j = s; j < s + len; j++) begin
            t              = ref_w[j];
            ref_w[j]       = (t + ref_w[j + len]) % Q;
            ref_w[j + len] = (z * ((ref_w[j + len] - t + Q) % Q)) % Q;
          end
        end
      for (int i = 0; i < N; i++) ref_w[i] = (ref_w[i] * F) % Q;
    end
  endtask

  task automatic load_f;
    for (int i = 0; i < N; i++) f[i] = vec[i][W-1:0];
  endtask

  task automatic take_fhat;
    for (int i = 0; i < N; i++) vec[i] = longint'(f_hat[i]);
  endtask

  task automatic cmp_ref(input string tag);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s[%0d]", tag, i), longint'(f_hat[i]), ref_w[i]);
  endtask

  // Start a transform and wait (bounded) for done_ntt. glitch_at pulses a
  // stray start with the opposite mode; scramble trashes f and mode after LOAD.
  task automatic run(input bit m, input int exp_lat, input int glitch_at, input bit scramble);
    int edges = 0;
    @(negedge clk);
    start_ntt = 1'b1;
    mode      = m;
    @(posedge clk);
    #1 start_ntt = 1'b0;
    while (1) begin
      @(posedge clk);
      edges++;
      #1;
      if (done_ntt) break;
      if (edges >= exp_lat + 20) break;
      if (scramble && edges == 2) begin
        for (int i = 0; i < N; i++) f[i] = $urandom;
        mode = ~m;
      end
      if (edges == glitch_at) begin
        start_ntt = 1'b1;
        mode      = ~m;
      end else begin
        start_ntt = 1'b0;
      end
    end
    chk(m ? "lat_inv" : "lat_fwd", edges, exp_lat);
  endtask

  initial begin
    int cnt;
    build_zetas();
    for (int i = 0; i < N; i++) f[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done_ntt, 0);
    chk("rst_fhat0", longint'(f_hat[0]), 0);
    chk("rst_fhatN", longint'(f_hat[N-1]), 0);
    @(negedge clk) rst = 1'b0;

    // Delta, forward: even outputs 1, odd 0
    for (int i = 0; i < N; i++) vec[i] = 0;
    vec[0] = 1;
    load_f();
    run(1'b0, LAT_FWD, -1, 1'b0);
    for (int i = 0; i < N; i++)
      chk($sformatf("delta[%0d]", i), longint'(f_hat[i]), (i % 2 == 0) ? 1 : 0);

    // X, forward then inverse (back-to-back start)
    for (int i = 0; i < N; i++) vec[i] = 0;
    vec[1] = 1;
    load_f();
    run(1'b0, LAT_FWD, -1, 1'b0);
    for (int i = 0; i < N; i++)
      chk($sformatf("xfwd[%0d]", i), longint'(f_hat[i]), (i % 2 == 1) ? 1 : 0);
    take_fhat();
    load_f();
    run(1'b1, LAT_INV, -1, 1'b0);
    for (int i = 0; i < N; i++)
      chk($sformatf("xinv[%0d]", i), longint'(f_hat[i]), (i == 1) ? 1 : 0);

    // Random round trips, inputs scrambled after LOAD
    repeat (2) begin
      for (int i = 0; i < N; i++) begin
        vec[i]  = longint'($urandom_range(0, Q - 1));
        orig[i] = vec[i];
      end
      model(1'b0);
      load_f();
      run(1'b0, LAT_FWD, -1, 1'b1);
      cmp_ref("rnd_fwd");
      take_fhat();
      model(1'b1);
      load_f();
      run(1'b1, LAT_INV, -1, 1'b1);
      cmp_ref("rnd_inv");
      for (int i = 0; i < N; i++)
        chk($sformatf("rnd_trip[%0d]", i), longint'(f_hat[i]), orig[i]);
    end

    // Full-width signed random inputs, forward
    for (int i = 0; i < N; i++) vec[i] = longint'(int'($urandom));
    model(1'b0);
    load_f();
    run(1'b0, LAT_FWD, -1, 1'b0);
    cmp_ref("wide_fwd");

    // Range / negative inputs
    for (int i = 0; i < N; i++) vec[i] = 0;
    vec[0] = -1;
    vec[5] = Q + 7;
    load_f();
    run(1'b0, LAT_FWD, -1, 1'b0);
    take_fhat();
    load_f();
    run(1'b1, LAT_INV, -1, 1'b0);
    for (int i = 0; i < N; i++)
      chk($sformatf("neg[%0d]", i), longint'(f_hat[i]), (i == 0) ? 3328 : (i == 5) ? 7 : 0);

    // Stray start (mode=1) during a forward run is ignored
    for (int i = 0; i < N; i++) vec[i] = longint'($urandom_range(0, Q - 1));
    model(1'b0);
    load_f();
    run(1'b0, LAT_FWD, 100, 1'b0);
    cmp_ref("ign_fwd");
    cnt = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (done_ntt) cnt++;
      if (busy) cnt++;
    end
    chk("ign_extra_activity", cnt, 0);
    chk("hold_fhat0", longint'(f_hat[0]), ref_w[0]);
    chk("hold_fhat77", longint'(f_hat[77]), ref_w[77]);

    // Reset mid-run
    for (int i = 0; i < N; i++) vec[i] = longint'($urandom_range(0, Q - 1));
    load_f();
    @(negedge clk);
    start_ntt = 1'b1;
    mode      = 1'b0;
    @(posedge clk);
    #1 start_ntt = 1'b0;
    repeat (500) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done_ntt, 0);
    for (int i = 0; i < N; i++)
      chk($sformatf("mid_rst_fhat[%0d]", i), longint'(f_hat[i]), 0);
    @(negedge clk) rst = 1'b0;
    cnt = 0;
    repeat (1200) begin
      @(posedge clk);
      #1;
      if (done_ntt) cnt++;
    end
    chk("mid_rst_no_done", cnt, 0);
    model(1'b0);
    run(1'b0, LAT_FWD, -1, 1'b0);
    cmp_ref("post_rst_fwd");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
